// File: rtl/simmem_pkg.sv
// Shared definitions for the simulated-memory response path.
// Holds the sizing defaults used by both the release scheduler and the
// linked-list response bank, plus the delay-slot state record.
package simmem_pkg;

  localparam int unsigned IDWidth     = 4;
  localparam int unsigned NumSlots    = 8;
  localparam int unsigned DelayWidth  = 8;
  localparam int unsigned CreditWidth = 6;
  localparam int unsigned NumIds      = 2 ** IDWidth;

  // One delay slot: a request waiting for its delay to elapse.
  typedef struct packed {
    logic                  valid;
    logic [IDWidth-1:0]    id;
    logic [DelayWidth-1:0] cnt;
  } slot_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// One delay slot of the release scheduler.
// A free slot captures (id, delay) on load_i. A valid slot counts down one
// per cycle; in the cycle its counter is zero it raises expire_o and goes
// invalid at the following edge.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   load_i          capture load_id_i/load_delay_i (only honoured when free)
//   load_id_i       ID of the request being loaded
//   load_delay_i    delay of the request being loaded
//   valid_o         slot currently holds a request
//   id_o            ID held by the slot
//   expire_o        slot expires this cycle (valid and counter at zero)
module simmem_delay_slot
  import simmem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [IDWidth-1:0]    load_id_i,
  input  logic [DelayWidth-1:0] load_delay_i,
  output logic                  valid_o,
  output logic [IDWidth-1:0]    id_o,
  output logic                  expire_o
);

  slot_t slot_q;
  slot_t slot_d;

  assign valid_o  = slot_q.valid;
  assign id_o     = slot_q.id;
  assign expire_o = slot_q.valid && (slot_q.cnt == '0);

  // An expiring slot still reads as valid this cycle, so it cannot be
  // reloaded until the next one.
  always_comb begin
    slot_d = slot_q;
    if (slot_q.valid) begin
      if (expire_o) begin
        slot_d.valid = 1'b0;
      end else begin
        slot_d.cnt = slot_q.cnt - DelayWidth'(1);
      end
    end else if (load_i) begin
      slot_d.valid = 1'b1;
      slot_d.id    = load_id_i;
      slot_d.cnt   = load_delay_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Release scheduler for the simulated-memory response bank.
// Each accepted request waits in a delay slot; when it expires it turns
// into a release credit for its ID. release_en_o[id] is high while that ID
// holds a credit; every response the bank reports on the consume port
// spends one credit.
// Handshake: a request transfers in a cycle where req_valid_i and
// req_ready_o are both high; req_ready_o never depends on req_valid_i, and
// the offer may change freely while ready is low. consume_valid_i is a
// single-cycle report with no back-pressure.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_valid_i       new request offered
//   req_ready_o       a slot is free and the ID is not saturated
//   req_id_i          request ID
//   req_delay_i       request delay in cycles
//   consume_valid_i   bank emitted one response this cycle
//   consume_id_i      ID of that response
//   release_en_o      per-ID release enable (credit nonzero)
//   busy_o            any slot valid or any credit nonzero
module simmem_release_scheduler
  import simmem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [IDWidth-1:0]    req_id_i,
  input  logic [DelayWidth-1:0] req_delay_i,
  input  logic                  consume_valid_i,
  input  logic [IDWidth-1:0]    consume_id_i,
  output logic [NumIds-1:0]     release_en_o,
  output logic                  busy_o
);

  logic [NumSlots-1:0] slot_valid;
  logic [NumSlots-1:0] slot_expire;
  logic [NumSlots-1:0] slot_load;
  logic [IDWidth-1:0]  slot_id [NumSlots];

  logic [NumSlots-1:0] free_onehot;
  logic                any_free;
  logic                accept;

  // Outstanding counts pending slots plus credits, so credit <= outstanding
  // and neither counter can overflow once outstanding is capped.
  logic [CreditWidth-1:0] credit_q [NumIds];
  logic [CreditWidth-1:0] credit_d [NumIds];
  logic [CreditWidth-1:0] outst_q  [NumIds];
  logic [CreditWidth-1:0] outst_d  [NumIds];
  logic [CreditWidth-1:0] n_exp    [NumIds];
  logic [NumIds-1:0]      cons_hit;
  logic [NumIds-1:0]      acc_hit;
  logic [NumIds-1:0]      credit_nz;

  // Lowest-index free slot.
  always_comb begin
    free_onehot = '0;
    any_free    = 1'b0;
    for (int s = 0; s < NumSlots; s++) begin
      if (!slot_valid[s] && !any_free) begin
        free_onehot[s] = 1'b1;
        any_free       = 1'b1;
      end
    end
  end

  assign req_ready_o = !rst_i && any_free && (outst_q[req_id_i] != '1);
  assign accept      = req_valid_i && req_ready_o;
  assign slot_load   = {NumSlots{accept}} & free_onehot;

  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    simmem_delay_slot u_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (slot_load[s]),
      .load_id_i    (req_id_i),
      .load_delay_i (req_delay_i),
      .valid_o      (slot_valid[s]),
      .id_o         (slot_id[s]),
      .expire_o     (slot_expire[s])
    );
  end

  // Number of slots of each ID expiring this cycle.
  always_comb begin
    n_exp = '{default: '0};
    for (int x = 0; x < NumIds; x++) begin
      for (int s = 0; s < NumSlots; s++) begin
        if (slot_expire[s] && (slot_id[s] == IDWidth'(x))) begin
          n_exp[x] = n_exp[x] + CreditWidth'(1);
        end
      end
    end
  end

  // A consume against an empty credit is a protocol error and is ignored.
  always_comb begin
    cons_hit = '0;
    acc_hit  = '0;
    if (consume_valid_i && (credit_q[consume_id_i] != '0)) begin
      cons_hit[consume_id_i] = 1'b1;
    end
    if (accept) begin
      acc_hit[req_id_i] = 1'b1;
    end
  end

  always_comb begin
    credit_d = credit_q;
    outst_d  = outst_q;
    for (int x = 0; x < NumIds; x++) begin
      credit_d[x] = credit_q[x] + n_exp[x] - CreditWidth'(cons_hit[x]);
      outst_d[x]  = outst_q[x] + CreditWidth'(acc_hit[x]) - CreditWidth'(cons_hit[x]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q <= '{default: '0};
      outst_q  <= '{default: '0};
    end else begin
      credit_q <= credit_d;
      outst_q  <= outst_d;
    end
  end

  always_comb begin
    credit_nz = '0;
    for (int x = 0; x < NumIds; x++) begin
      credit_nz[x] = (credit_q[x] != '0);
    end
  end

  assign release_en_o = rst_i ? '0 : credit_nz;
  assign busy_o       = !rst_i && ((|slot_valid) || (|credit_nz));

  consume_has_credit: assert property (
    @(posedge clk_i) disable iff (rst_i)
    consume_valid_i |-> (credit_q[consume_id_i] != '0)
  );

endmodule

// File: tb/tb_simmem_release_scheduler.sv
module tb_simmem_release_scheduler;
  import simmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [IDWidth-1:0]    req_id = '0;
  logic [DelayWidth-1:0] req_delay = '0;
  logic                  consume_valid = 1'b0;
  logic [IDWidth-1:0]    consume_id = '0;
  logic [NumIds-1:0]     release_en;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  simmem_release_scheduler dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_id_i        (req_id),
    .req_delay_i     (req_delay),
    .consume_valid_i (consume_valid),
    .consume_id_i    (consume_id),
    .release_en_o    (release_en),
    .busy_o          (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // Each pending request is {id, cycle in which its credit first appears}.
  logic [35:0] exp_q[$];
  int credit_m [NumIds];
  int outst_m  [NumIds];

  always @(negedge clk) begin
    logic [NumIds-1:0] e_rel;
    logic e_busy;
    logic e_rdy;
    logic [35:0] keep_q[$];
    e_rel  = '0;
    e_busy = 1'b0;
    e_rdy  = 1'b0;
    if (!rst) begin
      for (int x = 0; x < NumIds; x++) begin
        e_rel[x] = (credit_m[x] > 0);
      end
      e_busy = (exp_q.size() > 0) || (e_rel != '0);
      e_rdy  = (exp_q.size() < NumSlots) && (outst_m[req_id] < 63);
    end
    check("model_release_en", 32'(release_en), 32'(e_rel));
    check("model_busy", 32'(busy), 32'(e_busy));
    check("model_req_ready", 32'(req_ready), 32'(e_rdy));
    if (rst) begin
      exp_q.delete();
      for (int x = 0; x < NumIds; x++) begin
        credit_m[x] = 0;
        outst_m[x]  = 0;
      end
    end else begin
      if (req_valid && e_rdy) begin
        exp_q.push_back({req_id, 32'(cyc + 2 + int'(req_delay))});
        outst_m[req_id]++;
      end
      if (consume_valid && credit_m[consume_id] > 0) begin
        credit_m[consume_id]--;
        outst_m[consume_id]--;
      end
      keep_q.delete();
      foreach (exp_q[i]) begin
        if (int'(exp_q[i][31:0]) == cyc + 1) credit_m[exp_q[i][35:32]]++;
        else keep_q.push_back(exp_q[i]);
      end
      exp_q = keep_q;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IDWidth-1:0] id, input logic [DelayWidth-1:0] d,
                      input int budget, output int acc_cyc);
    bit done;
    done      = 1'b0;
    acc_cyc   = -1;
    req_valid = 1'b1;
    req_id    = id;
    req_delay = d;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout id=%0d got=no_accept exp=accept", id);
    end
  endtask

  task automatic consume(input logic [IDWidth-1:0] id);
    consume_valid = 1'b1;
    consume_id    = id;
    tick();
    consume_valid = 1'b0;
  endtask

  // Spend every credit the model says exists until nothing is pending.
  task automatic drain();
    int i;
    bit spent;
    bit any;
    i = 0;
    any = 1'b1;
    while (any && i < 600) begin
      any = (exp_q.size() > 0);
      spent = 1'b0;
      for (int x = 0; x < NumIds; x++) begin
        if (credit_m[x] > 0) any = 1'b1;
        if (credit_m[x] > 0 && !spent) begin
          spent = 1'b1;
          consume(IDWidth'(x));
        end
      end
      if (any && !spent) tick();
      i++;
    end
    if (any) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout got=pending exp=empty");
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t, t2, t0, tmp;

    // Reset
    repeat (3) tick();
    @(negedge clk);
    check("reset_release_en", 32'(release_en), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single request id=3 D=0: release at T+2, consume at T+4 clears at T+5.
    send(4'd3, 8'd0, 10, t);
    @(negedge clk);
    check("t1_rel_T+1", 32'(release_en[3]), 32'h0);
    tick();
    @(negedge clk);
    check("t1_rel_T+2", 32'(release_en[3]), 32'h1);
    tick();
    tick();
    consume(4'd3);
    @(negedge clk);
    check("t1_rel_after_consume", 32'(release_en[3]), 32'h0);
    check("t1_busy_after_consume", 32'(busy), 32'h0);

    // Two requests id=5 D=4 back to back.
    tick();
    send(4'd5, 8'd4, 10, t);
    send(4'd5, 8'd4, 10, t2);
    check("t2_back_to_back", 32'(t2), 32'(t + 1));
    repeat (3) tick();
    @(negedge clk);
    check("t2_rel_T+5", 32'(release_en[5]), 32'h0);
    tick();
    @(negedge clk);
    check("t2_rel_T+6", 32'(release_en[5]), 32'h1);
    tick();
    consume(4'd5);
    @(negedge clk);
    check("t2_rel_after_1st_consume", 32'(release_en[5]), 32'h1);
    tick();
    consume(4'd5);
    @(negedge clk);
    check("t2_rel_after_2nd_consume", 32'(release_en[5]), 32'h0);

    // Fill all slots with D=200; ninth offer waits for the first expiry.
    tick();
    for (int i = 0; i < NumSlots; i++) begin
      send(4'd1, 8'd200, 10, tmp);
      if (i == 0) t0 = tmp;
    end
    req_valid = 1'b1;
    req_id    = 4'd1;
    req_delay = 8'd0;
    @(negedge clk);
    check("t3_full_ready", 32'(req_ready), 32'h0);
    tick();
    send(4'd1, 8'd0, 300, t);
    check("t3_reuse_cycle", 32'(t), 32'(t0 + 202));
    drain();

    // Expiry and consume of id=2 in the same cycle.
    tick();
    send(4'd2, 8'd0, 10, t);
    send(4'd2, 8'd3, 10, t2);
    check("t4_back_to_back", 32'(t2), 32'(t + 1));
    @(negedge clk);
    check("t4_rel_T+2", 32'(release_en[2]), 32'h1);
    tick();
    @(negedge clk);
    check("t4_rel_T+3", 32'(release_en[2]), 32'h1);
    tick();
    @(negedge clk);
    check("t4_rel_T+4", 32'(release_en[2]), 32'h1);
    tick();
    consume(4'd2);
    @(negedge clk);
    check("t4_rel_after_overlap", 32'(release_en[2]), 32'h1);
    tick();
    consume(4'd2);
    @(negedge clk);
    check("t4_rel_final", 32'(release_en[2]), 32'h0);

    // Reset while four slots are counting.
    tick();
    for (int i = 0; i < 4; i++) begin
      send(IDWidth'(8 + i), 8'd20, 10, tmp);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_release_en", 32'(release_en), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after_rst", 32'(req_ready), 32'h1);
    repeat (40) tick();
    @(negedge clk);
    check("t5_no_release_after_rst", 32'(release_en), 32'h0);
    check("t5_idle_after_rst", 32'(busy), 32'h0);

    // Saturate outstanding[7].
    tick();
    for (int i = 0; i < 63; i++) begin
      send(4'd7, 8'd0, 10, tmp);
    end
    req_id = 4'd7;
    @(negedge clk);
    check("t6_ready_id7_sat", 32'(req_ready), 32'h0);
    tick();
    req_id = 4'd6;
    @(negedge clk);
    check("t6_ready_id6", 32'(req_ready), 32'h1);
    tick();
    req_id = 4'd7;
    consume(4'd7);
    @(negedge clk);
    check("t6_ready_id7_restored", 32'(req_ready), 32'h1);
    tick();
    drain();
    tick();
    @(negedge clk);
    check("end_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
